food_tracker: RTL

Food consumer and eat detector for the snake game. It takes the free-running food-candidate coordinates from the food generator, latches one valid candidate as the current food, and watches the snake head on every game tick. On a hit it pulses `eaten`, bumps the score and re-arms with a fresh candidate. It sits between the food generator and the snake body/length logic, in the `clk1` domain.

---
 rtl/food_tracker.sv | 106 ++++++++++
 1 files changed

// File: rtl/food_tracker.sv
// Food consumer for the snake game: latches a legal food candidate, detects the
// head eating it, pulses eaten and keeps a saturating score.
module food_tracker #(
  parameter int SIZE    = 8,
  parameter int X_MIN   = 151,
  parameter int X_MAX   = 777,
  parameter int Y_MIN   = 42,
  parameter int Y_MAX   = 508,
  parameter int SCORE_W = 8
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               pause,
  input  logic [9:0]         xHead,
  input  logic [9:0]         yHead,
  input  logic [9:0]         xCand,
  input  logic [9:0]         yCand,
  output logic [9:0]         xFood,
  output logic [9:0]         yFood,
  output logic               food_valid,
  output logic               eaten,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {LOAD, ARMED, EAT} state_t;

  localparam logic [10:0] SZ   = 11'(SIZE);
  localparam logic [9:0]  X_LO = 10'(X_MIN);
  localparam logic [9:0]  X_HI = 10'(X_MAX);
  localparam logic [9:0]  Y_LO = 10'(Y_MIN);
  localparam logic [9:0]  Y_HI = 10'(Y_MAX);

  state_t     state_reg, state_next;
  logic [9:0] hx, hy;
  logic       step;
  logic       cand_ok;
  logic       accept;
  logic       hit;

  // Sums are widened to 11 bits so coordinates near 1023 cannot wrap.
  function automatic logic ov(input logic [9:0] ax, input logic [9:0] ay,
                              input logic [9:0] bx, input logic [9:0] by);
    return ({1'b0, ax} + SZ > {1'b0, bx}) && ({1'b0, bx} + SZ > {1'b0, ax}) &&
           ({1'b0, ay} + SZ > {1'b0, by}) && ({1'b0, by} + SZ > {1'b0, ay});
  endfunction

  assign step    = tick & ~pause;
  assign cand_ok = (xCand >= X_LO) && (xCand <= X_HI) &&
                   (yCand >= Y_LO) && (yCand <= Y_HI) &&
                   !ov(xCand, yCand, hx, hy);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    hit        = 1'b0;
    case (state_reg)
      LOAD: begin
        if (cand_ok) begin
          accept     = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (step && ov(xHead, yHead, xFood, yFood)) begin
          hit        = 1'b1;
          state_next = EAT;
        end
      end
      EAT:     state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= LOAD;
      hx         <= '0;
      hy         <= '0;
      xFood      <= '0;
      yFood      <= '0;
      food_valid <= 1'b0;
      eaten      <= 1'b0;
      score      <= '0;
    end else begin
      state_reg <= state_next;
      eaten     <= hit;
      if (step) begin
        hx <= xHead;
        hy <= yHead;
      end
      if (accept) begin
        xFood      <= xCand;
        yFood      <= yCand;
        food_valid <= 1'b1;
      end
      // Leaving EAT: food position is kept, only the valid flag drops.
      if (state_reg == EAT) begin
        food_valid <= 1'b0;
        if (score != {SCORE_W{1'b1}})
          score <= score + SCORE_W'(1);
      end
    end
  end

endmodule
